// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_event_arbiter : round-robin arbiter turning per-channel edge pulses
//                      into a ready/valid event stream with overflow flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [NCH-1:0] pos_edge,
  input  logic [NCH-1:0] neg_edge,
  input  logic [NCH-1:0] chan_en,
  input  logic           clr_ovf,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CW-1:0]  evt_chan,
  output logic           evt_pol,
  output logic [NCH-1:0] ovf,
  output logic           busy
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] pend_pos_q, pend_pos_d;
  logic [NCH-1:0] pend_neg_q, pend_neg_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  evt_chan_q, evt_chan_d;
  logic           evt_pol_q, evt_pol_d;

  logic [NCH-1:0] elig;
  logic [NCH-1:0] clr_pos;
  logic [NCH-1:0] clr_neg;
  logic [NCH-1:0] kept_pos;
  logic [NCH-1:0] kept_neg;
  logic [CW-1:0]  next_ptr;
  logic [CW-1:0]  search_start;
  logic [CW-1:0]  grant_chan;
  logic           grant_pos;
  logic           found;
  logic           handshake;
  logic           grant;

  function automatic int wrap_idx(input int start, input int k);
    return (start + k) % NCH;
  endfunction

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    evt_chan_d   = evt_chan_q;
    evt_pol_d    = evt_pol_q;
    found        = 1'b0;
    grant_chan   = '0;
    grant_pos    = 1'b0;
    clr_pos      = '0;
    clr_neg      = '0;
    kept_pos     = '0;
    kept_neg     = '0;
    pend_pos_d   = '0;
    pend_neg_d   = '0;
    ovf_d        = clr_ovf ? '0 : ovf_q;

    // Disabled channels are masked so a just-disabled channel is never granted.
    elig         = (pend_pos_q | pend_neg_q) & chan_en;
    handshake    = (state_q == PRESENT) && evt_ready;
    next_ptr     = CW'((int'(evt_chan_q) + 1) % NCH);
    search_start = handshake ? next_ptr : rr_ptr_q;

    for (int k = 0; k < NCH; k++) begin
      if (!found && elig[wrap_idx(int'(search_start), k)]) begin
        found      = 1'b1;
        grant_chan = CW'(wrap_idx(int'(search_start), k));
        grant_pos  = pend_pos_q[wrap_idx(int'(search_start), k)];
      end
    end

    grant = found && ((state_q == IDLE) || handshake);

    for (int i = 0; i < NCH; i++) begin
      clr_pos[i]    = grant && grant_pos && (grant_chan == CW'(i));
      clr_neg[i]    = grant && !grant_pos && (grant_chan == CW'(i));
      kept_pos[i]   = pend_pos_q[i] & ~clr_pos[i];
      kept_neg[i]   = pend_neg_q[i] & ~clr_neg[i];
      pend_pos_d[i] = chan_en[i] & (kept_pos[i] | pos_edge[i]);
      pend_neg_d[i] = chan_en[i] & (kept_neg[i] | neg_edge[i]);
      // A fresh pulse onto a still-pending bit is dropped and flagged.
      if (chan_en[i] && ((kept_pos[i] && pos_edge[i]) || (kept_neg[i] && neg_edge[i]))) begin
        ovf_d[i] = 1'b1;
      end
    end

    if (handshake) begin
      rr_ptr_d = next_ptr;
      state_d  = IDLE;
    end
    if (grant) begin
      state_d    = PRESENT;
      evt_chan_d = grant_chan;
      evt_pol_d  = grant_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      pend_pos_q <= '0;
      pend_neg_q <= '0;
      ovf_q      <= '0;
      rr_ptr_q   <= '0;
      evt_chan_q <= '0;
      evt_pol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_pos_q <= pend_pos_d;
      pend_neg_q <= pend_neg_d;
      ovf_q      <= ovf_d;
      rr_ptr_q   <= rr_ptr_d;
      evt_chan_q <= evt_chan_d;
      evt_pol_q  <= evt_pol_d;
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign evt_chan  = evt_chan_q;
  assign evt_pol   = evt_pol_q;
  assign ovf       = ovf_q;
  assign busy      = (|pend_pos_q) || (|pend_neg_q) || evt_valid;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter : directed vector bench for edge_event_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] pos_edge;
  logic [3:0] neg_edge;
  logic [3:0] chan_en;
  logic       clr_ovf;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic       evt_pol;
  logic [3:0] ovf;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_arbiter #(.NCH(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .chan_en   (chan_en),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_pol   (evt_pol),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] en;
    logic       clr;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_chan;
    logic       e_pol;
    logic [3:0] e_ovf;
    logic       e_busy;
  } vec_t;

  task automatic check1(input string name, input string what, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h want %h", name, what, got, want);
    end
  endtask

  // One clock: drive inputs, clock, then check outputs 1ns after the edge.
  task automatic cyc(input string name, input logic rstn, input logic [3:0] pos, input logic [3:0] neg,
                     input logic [3:0] en, input logic clr, input logic rdy,
                     input logic e_valid, input logic [1:0] e_chan, input logic e_pol,
                     input logic [3:0] e_ovf, input logic e_busy);
    n_rst     = rstn;
    pos_edge  = pos;
    neg_edge  = neg;
    chan_en   = en;
    clr_ovf   = clr;
    evt_ready = rdy;
    @(posedge clk);
    #1;
    check1(name, "evt_valid", {3'b0, evt_valid}, {3'b0, e_valid});
    check1(name, "ovf", ovf, e_ovf);
    check1(name, "busy", {3'b0, busy}, {3'b0, e_busy});
    if (e_valid) begin
      check1(name, "evt_chan", {2'b0, evt_chan}, {2'b0, e_chan});
      check1(name, "evt_pol", {3'b0, evt_pol}, {3'b0, e_pol});
    end
  endtask

  vec_t vecs[$];

  initial begin
    n_rst = 1'b0; pos_edge = '0; neg_edge = '0; chan_en = 4'hF; clr_ovf = 1'b0; evt_ready = 1'b1;

    //            rstn  pos     neg     en      clr   rdy   val   ch     pol   ovf     busy
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    // all four channels at once, then wrap to channel 0
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b0001, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    // single pos_edge[2]: valid two edges later, for one cycle
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});
    // both polarities on channel 1: rising first, then falling
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0});

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].pos, vecs[i].neg, vecs[i].en, vecs[i].clr,
          vecs[i].rdy, vecs[i].e_valid, vecs[i].e_chan, vecs[i].e_pol, vecs[i].e_ovf, vecs[i].e_busy);
    end

    // Stalled consumer, repeated pulses on channel 3 (rr_ptr = 2 here)
    cyc("stall_p1",   1'b1, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
    cyc("stall_gnt",  1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1);
    cyc("stall_p2",   1'b1, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1);
    cyc("stall_p3",   1'b1, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1);
    cyc("clr_vs_ovf", 1'b1, 4'b1000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1);
    cyc("clr_ovf",    1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1);
    cyc("drain_kept", 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1);
    cyc("drain_done", 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Disable channel 0 while its rising event is presented (rr_ptr = 0)
    cyc("dis_pulse",  1'b1, 4'b0001, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
    cyc("dis_gnt",    1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1);
    cyc("dis_drop",   1'b1, 4'b0000, 4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1);
    cyc("dis_hs",     1'b1, 4'b0000, 4'b0000, 4'b1110, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    cyc("dis_after",  1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Reset mid-PRESENT with pending bits and an overflow (rr_ptr = 1 before reset)
    cyc("rst_pend",   1'b1, 4'b1110, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
    cyc("rst_gnt",    1'b1, 4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0100, 1'b1);
    cyc("rst_edge",   1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    cyc("rst_quiet",  1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
    cyc("rst_p",      1'b1, 4'b1001, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1);
    cyc("rst_first",  1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1);
    cyc("rst_second", 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b1);
    cyc("rst_end",    1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of edge-detector channels served (legal range 1..16).
REQ-002 SHALL have parameter CW, default $clog2(NCH) with a minimum of 1, meaning the width of the channel index.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port pos_edge  input  NCH  per-channel rising-edge pulse, one cycle wide, from edge detectors.
REQ-006 SHALL have port neg_edge  input  NCH  per-channel falling-edge pulse, one cycle wide.
REQ-007 SHALL have port chan_en  input  NCH  per-channel enable; 0 = ignore that channel's pulses.
REQ-008 SHALL have port clr_ovf  input  1  single-cycle pulse clearing all overflow flags.
REQ-009 SHALL have port evt_valid  output  1  an event is presented on evt_chan/evt_pol.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the presented event.
REQ-011 SHALL have port evt_chan  output  CW  channel index of the presented event.
REQ-012 SHALL have port evt_pol  output  1  event polarity: 1 = rising, 0 = falling.
REQ-013 SHALL have port ovf  output  NCH  sticky per-channel overflow flags.
REQ-014 SHALL have port busy  output  1  high when any pending bit is set or evt_valid is high.

Function
REQ-015 SHALL keep registered pending bits pend_pos[i] and pend_neg[i] per channel.
REQ-016 SHALL set pend_pos[i] on the clock edge that samples pos_edge[i]=1 while chan_en[i]=1; neg_edge/pend_neg likewise.
REQ-017 SHALL implement two states: IDLE (evt_valid=0) and PRESENT (evt_valid=1).
REQ-018 SHALL, in IDLE with any pending bit set, grant one event, load evt_chan/evt_pol, clear the granted pending bit, and enter PRESENT on the same edge.
REQ-019 SHALL select the grant round-robin: search channels from rr_ptr upward, wrapping NCH-1 -> 0; the first channel found with any pending bit wins.
REQ-020 SHALL, within the winning channel, grant rising before falling when both are pending; the falling event remains pending.
REQ-021 SHALL hold evt_valid, evt_chan and evt_pol stable in PRESENT until an edge samples evt_valid=1 and evt_ready=1.
REQ-022 SHALL, on handshake, set rr_ptr to (evt_chan+1) mod NCH; if any pending bit is set, grant the next event on that same edge (stay in PRESENT, back-to-back); otherwise go to IDLE.
REQ-023 SHALL give a minimum latency of 2 edges: a pulse sampled at edge k produces evt_valid=1 after edge k+1 when idle with nothing else pending.
REQ-024 SHALL, when a pulse arrives for a pending bit not cleared that cycle, keep the bit set, drop the new event and set ovf[i].
REQ-025 SHALL, when a pulse arrives on the same edge its pending bit is granted/cleared, leave the bit set and not flag overflow.
REQ-026 SHALL, when chan_en[i]=0, clear pend_pos[i] and pend_neg[i] and ignore pulses; an event already presented for channel i still completes its handshake.
REQ-027 SHALL have clr_ovf clear all ovf bits; a same-edge overflow on channel i takes priority (ovf[i] ends set).
REQ-028 SHALL, with NCH=1, always grant channel 0; rr_ptr stays 0.
REQ-029 SHALL never lose an event except by the overflow (REQ-024) or disable (REQ-026) rules.

Reset
REQ-030 SHALL, on an edge with n_rst=0, clear all pending bits and ovf, set rr_ptr=0, enter IDLE, and drive evt_valid=0, evt_chan=0 and evt_pol=0; busy follows as 0.
REQ-031 SHALL have reset override everything, including mid-PRESENT, and discard the presented event.
REQ-032 SHALL ignore pulses sampled on the reset edge.

Verification
REQ-033 SHALL cover: single pos_edge[2] pulse with evt_ready=1 -> evt_valid high 2 edges later with chan=2, pol=1, for exactly one cycle; busy then 0.
REQ-034 SHALL cover: pos_edge=4'b1111 in one cycle with evt_ready held 1 -> events on channels 0,1,2,3 on consecutive cycles; then pos_edge[0] -> next grant is channel 0 after the wrap.
REQ-035 SHALL cover: pos_edge[1] and neg_edge[1] together -> (1,pol=1) then (1,pol=0).
REQ-036 SHALL cover: evt_ready=0 with three pos_edge[3] pulses -> one event presented and stable, ovf[3]=1, no second event for channel 3; clr_ovf -> ovf=0.
REQ-037 SHALL cover: chan_en[0] dropped while event (0,1) is presented and neg_edge[0] is pending -> presented event completes, pending neg is discarded.
REQ-038 SHALL cover: n_rst=0 asserted during PRESENT with bits pending -> next cycle evt_valid=0, ovf=0, busy=0, and the first later grant starts at channel 0.
